fib_arbiter: RTL

FIB_ARBITER -- requirements
Module: fib_arbiter

---
 rtl/fib_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fib_arbiter.sv
// fib_arbiter: two-requester round-robin front end for a single shared fib core.
// One transaction is in flight at a time: grant -> send param -> wait result -> return.
// Optional watchdog: define FIB_ARB_TIMEOUT_EN to abort a stuck core after TIMEOUT cycles.
//
// state  | meaning
// IDLE   | no transaction, arbitrating requests
// SEND   | presenting latched param to the core
// WAIT   | accepting the core result
// RETURN | holding result for the owner until it acks
module fib_arbiter #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s0_param_data,
  input  logic             s0_param_en,
  output logic             s0_param_ack,
  input  logic [WIDTH-1:0] s1_param_data,
  input  logic             s1_param_en,
  output logic             s1_param_ack,
  output logic [WIDTH-1:0] s0_result_data,
  output logic             s0_result_en,
  input  logic             s0_result_ack,
  output logic             s0_result_err,
  output logic [WIDTH-1:0] s1_result_data,
  output logic             s1_result_en,
  input  logic             s1_result_ack,
  output logic             s1_result_err,
  output logic [WIDTH-1:0] core_param_data,
  output logic             core_param_en,
  input  logic             core_param_ack,
  input  logic [WIDTH-1:0] core_result_data,
  input  logic             core_result_en,
  output logic             core_result_ack,
  output logic             core_rst
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RETURN} state_t;

  state_t           state;
  logic             owner;
  logic             last;
  logic             grant_sel;
  logic             any_req;
  logic             ack0_q;
  logic             ack1_q;
  logic [WIDTH-1:0] param_q;
  logic [WIDTH-1:0] result_q;

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          err_q;
  logic          core_rst_q;
  logic          expired;

  // Watchdog fires on the cycle the counter would reach TIMEOUT.
  assign expired = (cnt >= CNT_LAST);
`endif

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    any_req   = s0_param_en | s1_param_en;
    grant_sel = (s0_param_en && s1_param_en) ? ~last : s1_param_en;
  end

  // Transaction FSM with registered param ack pulses and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      param_q  <= '0;
      result_q <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
      cnt        <= '0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
      core_rst_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            owner   <= grant_sel;
            last    <= grant_sel;
            param_q <= grant_sel ? s1_param_data : s0_param_data;
            ack0_q  <= ~grant_sel;
            ack1_q  <= grant_sel;
            state   <= SEND;
`ifdef FIB_ARB_TIMEOUT_EN
            cnt   <= '0;
            err_q <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (core_param_ack) begin
            state <= WAIT;
          end
`ifdef FIB_ARB_TIMEOUT_EN
          else if (expired) begin
            result_q   <= '1;
            err_q      <= 1'b1;
            core_rst_q <= 1'b1;
            state      <= RETURN;
          end
          cnt <= cnt + 1'b1;
`endif
        end
        WAIT: begin
          if (core_result_en) begin
            result_q <= core_result_data;
            state    <= RETURN;
          end
`ifdef FIB_ARB_TIMEOUT_EN
          else if (expired) begin
            result_q   <= '1;
            err_q      <= 1'b1;
            core_rst_q <= 1'b1;
            state      <= RETURN;
          end
          cnt <= cnt + 1'b1;
`endif
        end
        RETURN: begin
          if (owner ? s1_result_ack : s0_result_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s0_param_ack    = ack0_q;
  assign s1_param_ack    = ack1_q;
  assign core_param_en   = (state == SEND);
  assign core_param_data = param_q;
  assign core_result_ack = (state == WAIT);
  assign s0_result_en    = (state == RETURN) && !owner;
  assign s1_result_en    = (state == RETURN) && owner;
  assign s0_result_data  = result_q;
  assign s1_result_data  = result_q;

`ifdef FIB_ARB_TIMEOUT_EN
  assign s0_result_err = s0_result_en & err_q;
  assign s1_result_err = s1_result_en & err_q;
  assign core_rst      = rst | core_rst_q;
`else
  assign s0_result_err = 1'b0;
  assign s1_result_err = 1'b0;
  assign core_rst      = rst;
`endif

endmodule
